// File: rtl/seq_divider_8x4.sv
// Iterative restoring unsigned divider: N-bit dividend / M-bit divisor,
// one quotient bit per clock under a start/busy/done handshake.
module seq_divider_8x4 #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [M-1:0] B,
  output logic [N-1:0] Quot,
  output logic [M-1:0] Rem,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [N-1:0]   dvd_r;
  logic [N-1:0]   quo_r;
  logic [M-1:0]   dvs_r;
  logic [M-1:0]   rem_r;
  logic [CW-1:0]  cnt_r;
  logic           dz_r;
  logic [N-1:0]   quot_r;
  logic [M-1:0]   rem_out_r;
  logic           busy_r;
  logic           done_r;
  logic           div_zero_r;

  logic [M:0]     shifted_s;
  logic [M-1:0]   trial_s;
  logic           qbit_s;
  logic           accept_s;

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  always_comb begin
    shifted_s = {rem_r, dvd_r[N-1]};
    trial_s   = shifted_s[M-1:0];
    qbit_s    = 1'b0;
    if (shifted_s >= {1'b0, dvs_r}) begin
      trial_s = M'(shifted_s - {1'b0, dvs_r});
      qbit_s  = 1'b1;
    end else begin
      trial_s = shifted_s[M-1:0];
      qbit_s  = 1'b0;
    end
  end

  // A request is taken in IDLE and also in DONE so operations can run back to back.
  always_comb begin
    accept_s = 1'b0;
    if (start && ((state_r == IDLE) || (state_r == DONE))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      dvd_r      <= {N{1'b0}};
      quo_r      <= {N{1'b0}};
      dvs_r      <= {M{1'b0}};
      rem_r      <= {M{1'b0}};
      cnt_r      <= {CW{1'b0}};
      dz_r       <= 1'b0;
      quot_r     <= {N{1'b0}};
      rem_out_r  <= {M{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        CALC: begin
          rem_r <= trial_s;
          dvd_r <= {dvd_r[N-2:0], 1'b0};
          quo_r <= {quo_r[N-2:0], qbit_s};
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          quot_r     <= dz_r ? {N{1'b1}} : quo_r;
          rem_out_r  <= dz_r ? {M{1'b0}} : rem_r;
          div_zero_r <= dz_r;
          done_r     <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase

      // A new operation overrides the idle transition; DONE still publishes the old result.
      if (accept_s) begin
        dvd_r <= A;
        dvs_r <= B;
        rem_r <= {M{1'b0}};
        quo_r <= {N{1'b0}};
        cnt_r <= CW'(N);
        dz_r  <= (B == {M{1'b0}});
        if (state_r == IDLE) begin
          div_zero_r <= 1'b0;
        end
        if (B == {M{1'b0}}) begin
          state_r <= DONE;
          busy_r  <= 1'b0;
        end else begin
          state_r <= CALC;
          busy_r  <= 1'b1;
        end
      end
    end
  end

  assign Quot     = quot_r;
  assign Rem      = rem_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;

endmodule

// File: doc/seq_divider_8x4.md
Name: seq_divider_8x4

Overview:
- Iterative restoring unsigned divider, the inverse operation of the 4x4 Wallace-tree multiplier.
- Divides an 8-bit dividend (the multiplier's product width) by a 4-bit divisor and returns an 8-bit quotient and a 4-bit remainder.
- Produces one quotient bit per clock under a start/busy/done handshake.
- Used to undo or check multiplier results and for scaling in the same datapath.

Parameters:
- N, 8, dividend and quotient width.
- M, 4, divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- A  input  N  dividend; captured on the accepted start.
- B  input  M  divisor; captured on the accepted start.
- Quot  output  N  quotient; valid when done=1, held until the next accepted start.
- Rem  output  M  remainder; valid when done=1, held until the next accepted start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse when results are valid.
- div_zero  output  1  set with done when captured B==0; held with results.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; Quot=0, Rem=0, busy=0, done=0, div_zero=0; internal registers cleared.
- Reset mid-operation aborts the division immediately with the same reset values. No partial result is produced.
- Reset has priority over start.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 with B!=0: capture A and B; partial remainder R=0 (width M+1); count=N; go to CALC.
  - start=1 with B==0: go to DONE with Quot=all ones, Rem=0, div_zero=1.
  - start=0: stay in IDLE.
- CALC, once per cycle:
  - R = {R[M-1:0], dividend MSB}; shift dividend left by 1.
  - If R >= {0,B}: R = R - B and shift in quotient bit 1; else shift in 0.
  - Decrement count. After the N-th iteration, go to DONE.
  - start is ignored in CALC; captured operands are unaffected by later changes on A and B.
- DONE:
  - done=1 for exactly this cycle; Quot and Rem are registered here.
  - div_zero=1 only for the divide-by-zero case, otherwise 0.
  - If start=1 in DONE, it is accepted as in IDLE (back-to-back operation with no idle gap); otherwise go to IDLE.
- Latency:
  - Start accepted at edge k gives done=1 in the cycle after edge k+N+1 (10 edges for N=8).
  - Divide-by-zero gives done=1 after edge k+1.
- busy=1 exactly N cycles per normal operation; busy=0 in IDLE and DONE.
- Arithmetic is unsigned.
  - Quotient range is 0..2^N-1 (A/1 = A). Remainder is always < B.
  - Invariant for every B!=0: Quot*B + Rem == A.
- Outputs never change between done and the next accepted start.
- div_zero is cleared on the next accepted start.

Test Plan:
- Reset, then A=255, B=15, start 1 cycle -> busy high for 8 cycles, done pulse 1 cycle, Quot=17, Rem=0, div_zero=0.
- A=200, B=7 -> Quot=28, Rem=4. A=5, B=9 -> Quot=0, Rem=5. A=173, B=1 -> Quot=173, Rem=0.
- A=100, B=0 -> done after edge k+1, Quot=255, Rem=0, div_zero=1, busy never high. A following start with A=9, B=3 -> Quot=3, Rem=0, div_zero=0.
- Start A=60, B=4; hold start high and change A/B during CALC -> the extra start is ignored, result Quot=15, Rem=0. Start high in the DONE cycle -> the new operation begins with no idle cycle.
- Start A=250, B=3; assert rst at CALC cycle 4 -> next cycle all outputs 0 and state IDLE. A new start A=250, B=3 -> Quot=83, Rem=1.
- Exhaustive sweep: all A in 0..255, B in 0..15 -> Quot==A/B and Rem==A%B for B!=0, div_zero=1 for B=0. Done latency exactly 10 edges (2 for B=0). Report PASS/ERROR per vector.
